fltc_checker: RTL and testbench

Duplicate-logic fault checker with built-in latent-fault self-test (BIST). Compares a functional vector against its redundant copy through two independent, registered compare trees and reports mission errors. After reset it walks an injected mismatch through every compare group to prove both trees can detect a fault. It drives the signal bundle consumed by the fault-checker input monitor: func, check, latent_error_*, cerr_*, latent_fault_tree and reset_n_delay.

---
 rtl/fltc_pkg.sv | 21 ++
 rtl/fltc_cmp_tree.sv | 42 ++++
 rtl/fltc_checker.sv | 139 +++++++++++++
 tb/tb_fltc_checker.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fltc_pkg.sv
// Shared types and sizing helpers for the duplicate-logic fault checker.
package fltc_pkg;

    typedef enum logic [2:0] {
        RST_WAIT,
        INJ,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    function automatic int ngrp(input int width, input int group);
        return width / group;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fltc_cmp_tree.sv
// Two-stage registered compare tree: per-group OR of the XOR difference, then OR of groups.
module fltc_cmp_tree
    import fltc_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int GROUP = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] func,
    input  logic [WIDTH-1:0] check,
    input  logic [WIDTH-1:0] mask_func,
    input  logic [WIDTH-1:0] mask_check,
    output logic             cerr
);

    localparam int NGRP = ngrp(WIDTH, GROUP);

    logic [WIDTH-1:0] diff;
    logic [NGRP-1:0]  grp_or;
    logic [NGRP-1:0]  grp_q;

    assign diff = (func ^ mask_func) ^ (check ^ mask_check);

    always_comb begin
        grp_or = '0;
        for (int i = 0; i < NGRP; i++) begin
            grp_or[i] = |diff[i*GROUP +: GROUP];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grp_q <= '0;
            cerr  <= 1'b0;
        end else begin
            grp_q <= grp_or;
            cerr  <= |grp_q;
        end
    end

endmodule

// File: rtl/fltc_checker.sv
// Duplicate-logic fault checker: two independent compare trees plus a post-reset
// walking-injection self-test that proves both trees detect a mismatch in every group.
//
// state    | meaning
// RST_WAIT | settle RST_DLY cycles after reset release
// INJ      | drive one-hot injection mask for group g, side s
// WAIT     | masks idle while the pulse moves through stage 1
// SAMPLE   | both trees must flag the injection; advance g/s
// DONE     | mission mode, downstream released
module fltc_checker
    import fltc_pkg::*;
#(
    parameter int WIDTH   = 1024,
    parameter int GROUP   = 64,
    parameter int RST_DLY = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] func,
    input  logic [WIDTH-1:0] check,
    output logic [WIDTH-1:0] latent_error_func,
    output logic [WIDTH-1:0] latent_error_check,
    output logic             cerr_func,
    output logic             cerr_check,
    output logic             mission_err,
    output logic             latent_fault_tree,
    output logic             reset_n_delay,
    output logic             bist_busy
);

    localparam int NGRP = ngrp(WIDTH, GROUP);
    localparam int GW   = cnt_w(NGRP);
    localparam int DW   = cnt_w(RST_DLY);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic          armed;
    logic [DW-1:0] dly_cnt, dly_cnt_nxt;
    logic [GW-1:0] grp, grp_nxt;
    logic          side, side_nxt;

    fltc_cmp_tree #(.WIDTH(WIDTH), .GROUP(GROUP)) u_tree_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .func       (func),
        .check      (check),
        .mask_func  (latent_error_func),
        .mask_check (latent_error_check),
        .cerr       (cerr_func)
    );

    fltc_cmp_tree #(.WIDTH(WIDTH), .GROUP(GROUP)) u_tree_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .func       (func),
        .check      (check),
        .mask_func  (latent_error_func),
        .mask_check (latent_error_check),
        .cerr       (cerr_check)
    );

    // armed rises on the first clock after release, so the settle count starts from a clean edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RST_WAIT;
            armed   <= 1'b0;
            dly_cnt <= DW'(RST_DLY - 1);
            grp     <= '0;
            side    <= 1'b0;
        end else begin
            state   <= state_nxt;
            armed   <= 1'b1;
            dly_cnt <= dly_cnt_nxt;
            grp     <= grp_nxt;
            side    <= side_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        grp_nxt     = grp;
        side_nxt    = side;
        case (state)
            RST_WAIT: begin
                if (armed) begin
                    if (dly_cnt == '0) state_nxt = INJ;
                    else               dly_cnt_nxt = dly_cnt - DW'(1);
                end
            end
            INJ:  state_nxt = WAIT;
            WAIT: state_nxt = SAMPLE;
            SAMPLE: begin
                if (!side) begin
                    side_nxt  = 1'b1;
                    state_nxt = INJ;
                end else if (grp == GW'(NGRP - 1)) begin
                    grp_nxt   = '0;
                    side_nxt  = 1'b0;
                    state_nxt = DONE;
                end else begin
                    grp_nxt   = grp + GW'(1);
                    side_nxt  = 1'b0;
                    state_nxt = INJ;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = RST_WAIT;
        endcase
    end

    // Side 0 hits the lowest bit of the group on func, side 1 the highest bit on check.
    always_comb begin
        latent_error_func  = '0;
        latent_error_check = '0;
        if (state == INJ) begin
            if (!side) latent_error_func  = ONE << (int'(grp) * GROUP);
            else       latent_error_check = ONE << (int'(grp) * GROUP + GROUP - 1);
        end
    end

    assign bist_busy     = armed && (state != DONE);
    assign reset_n_delay = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mission_err       <= 1'b0;
            latent_fault_tree <= 1'b0;
        end else begin
            if (state == SAMPLE && !(cerr_func && cerr_check))
                latent_fault_tree <= 1'b1;
            if (state == DONE && (cerr_func != cerr_check))
                latent_fault_tree <= 1'b1;
            if (state == DONE && (cerr_func || cerr_check))
                mission_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fltc_checker.sv
// Self-checking bench for fltc_checker: BIST walk, mission errors, latent miss, mid-BIST reset.
module tb_fltc_checker;

    localparam int W  = 1024;
    localparam int G  = 64;
    localparam int NG = W / G;
    localparam int RD = 4;
    localparam int BIST_LEN = RD + 6 * NG;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] func, check, lef, lec;
    logic         cf, cc, merr, lft, rnd, busy;

    logic [63:0]  func_s, check_s, lef_s, lec_s;
    logic         cf_s, cc_s, merr_s, lft_s, rnd_s, busy_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fltc_checker #(.WIDTH(W), .GROUP(G), .RST_DLY(RD)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .func               (func),
        .check              (check),
        .latent_error_func  (lef),
        .latent_error_check (lec),
        .cerr_func          (cf),
        .cerr_check         (cc),
        .mission_err        (merr),
        .latent_fault_tree  (lft),
        .reset_n_delay      (rnd),
        .bist_busy          (busy)
    );

    fltc_checker #(.WIDTH(64), .GROUP(64), .RST_DLY(4)) dut_small (
        .clk                (clk),
        .reset_n            (reset_n),
        .func               (func_s),
        .check              (check_s),
        .latent_error_func  (lef_s),
        .latent_error_check (lec_s),
        .cerr_func          (cf_s),
        .cerr_check         (cc_s),
        .mission_err        (merr_s),
        .latent_fault_tree  (lft_s),
        .reset_n_delay      (rnd_s),
        .bist_busy          (busy_s)
    );

    // Expected injection masks at sample i (i clocks after reset release).
    function automatic logic [W-1:0] model_mf(input int i);
        logic [W-1:0] m;
        int k;
        m = '0;
        k = i - (RD + 1);
        if (k >= 0 && k < 6 * NG && (k % 6) == 0) m[(k / 6) * G] = 1'b1;
        return m;
    endfunction

    function automatic logic [W-1:0] model_mc(input int i);
        logic [W-1:0] m;
        int k;
        m = '0;
        k = i - (RD + 1);
        if (k >= 0 && k < 6 * NG && (k % 6) == 3) m[(k / 6) * G + G - 1] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        func    = '0;
        check   = '0;
        tick();
        tick();
    endtask

    task automatic do_release();
        tick();
        reset_n = 1'b1;
    endtask

    // Walks the BIST from release, checking every cycle against the model.
    task automatic run_bist(input int hold_bit, input int abort_at);
        logic dflag [0:127];
        logic latent_exp;
        logic exp_c;
        logic exp_busy;
        int   k;
        latent_exp = 1'b0;
        dflag[0] = |(func ^ check);
        for (int i = 1; i <= BIST_LEN + 1; i++) begin
            tick();
            exp_c    = (i >= 2) ? dflag[i-2] : 1'b0;
            exp_busy = (i <= BIST_LEN);
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL bist_busy i=%0d got %b want %b", i, busy, exp_busy);
            end
            n_checks++;
            if (rnd !== !exp_busy) begin
                n_fail++;
                $display("FAIL reset_n_delay i=%0d got %b want %b", i, rnd, !exp_busy);
            end
            n_checks++;
            if (lef !== model_mf(i)) begin
                n_fail++;
                $display("FAIL mask_func i=%0d got %h want %h", i, lef, model_mf(i));
            end
            n_checks++;
            if (lec !== model_mc(i)) begin
                n_fail++;
                $display("FAIL mask_check i=%0d got %h want %h", i, lec, model_mc(i));
            end
            n_checks++;
            if (cf !== exp_c || cc !== exp_c) begin
                n_fail++;
                $display("FAIL bist_cerr i=%0d got %b%b want %b%b", i, cf, cc, exp_c, exp_c);
            end
            n_checks++;
            if (lft !== latent_exp) begin
                n_fail++;
                $display("FAIL bist_latent i=%0d got %b want %b", i, lft, latent_exp);
            end
            n_checks++;
            if (merr !== 1'b0) begin
                n_fail++;
                $display("FAIL bist_mission i=%0d got %b want 0", i, merr);
            end
            k = i - (RD + 1);
            if (k >= 0 && k < 6 * NG && (k % 3) == 2 && !exp_c) latent_exp = 1'b1;
            if (i == abort_at) return;
            if (hold_bit >= 0 && i == RD + 1 + 90) func[hold_bit] = 1'b0;
            dflag[i] = |(func ^ check ^ model_mf(i) ^ model_mc(i));
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int w = 0; w < W / 32; w++) func[w*32 +: 32] = $urandom;
        check = ~func;
        tick();
        tick();
        n_checks++;
        if ({lef, lec} !== '0 || {cf, cc, merr, lft, rnd, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 000000", {cf, cc, merr, lft, rnd, busy});
        end
        n_checks++;
        if ({lef_s, lec_s} !== '0 || {cf_s, cc_s, merr_s, lft_s, rnd_s, busy_s} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs_small got %b want 000000",
                     {cf_s, cc_s, merr_s, lft_s, rnd_s, busy_s});
        end
        func  = '0;
        check = '0;
    endtask

    task automatic test_bist();
        do_reset();
        do_release();
        run_bist(-1, -1);
    endtask

    task automatic test_bit517();
        func[517] = 1'b1;
        tick();
        func[517] = 1'b0;
        n_checks++;
        if (cf !== 1'b0 || cc !== 1'b0) begin
            n_fail++;
            $display("FAIL b517_early got %b%b want 00", cf, cc);
        end
        tick();
        n_checks++;
        if (cf !== 1'b1 || cc !== 1'b1 || merr !== 1'b0) begin
            n_fail++;
            $display("FAIL b517_cerr got cf=%b cc=%b merr=%b want 1 1 0", cf, cc, merr);
        end
        tick();
        n_checks++;
        if (cf !== 1'b0 || cc !== 1'b0 || merr !== 1'b1) begin
            n_fail++;
            $display("FAIL b517_mission got cf=%b cc=%b merr=%b want 0 0 1", cf, cc, merr);
        end
        repeat (5) tick();
        n_checks++;
        if (merr !== 1'b1 || rnd !== 1'b1 || lft !== 1'b0) begin
            n_fail++;
            $display("FAIL b517_sticky got merr=%b rnd=%b lft=%b want 1 1 0", merr, rnd, lft);
        end
    endtask

    task automatic test_random_mission();
        logic m [0:299];
        logic mexp;
        logic exp_c;
        int   b1, b2;
        do_reset();
        do_release();
        run_bist(-1, -1);
        mexp = 1'b0;
        for (int j = 0; j < 300; j++) begin
            if (j > 0) begin
                tick();
                exp_c = (j >= 2) ? m[j-2] : 1'b0;
                n_checks++;
                if (cf !== exp_c || cc !== exp_c) begin
                    n_fail++;
                    $display("FAIL mission_cerr j=%0d got %b%b want %b%b", j, cf, cc, exp_c, exp_c);
                end
                n_checks++;
                if (merr !== mexp || lft !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mission_flags j=%0d got merr=%b lft=%b want %b 0", j, merr, lft, mexp);
                end
                if (exp_c) mexp = 1'b1;
            end
            for (int w = 0; w < W / 32; w++) func[w*32 +: 32] = $urandom;
            check = func;
            b1 = $urandom_range(W - 1);
            b2 = (b1 + 1 + $urandom_range(W - 2)) % W;
            case ($urandom_range(7))
                0: check[b1] = ~check[b1];
                1: begin
                    check[b1] = ~check[b1];
                    check[b2] = ~check[b2];
                end
                default: ;
            endcase
            m[j] = (func != check);
        end
        func  = '0;
        check = '0;
    endtask

    task automatic test_reset_mid_bist();
        do_reset();
        do_release();
        run_bist(-1, RD + 1 + 42);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({lef, lec} !== '0 || {cf, cc, merr, lft, rnd, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL midbist_reset got %b masks_zero=%b want 000000 1",
                     {cf, cc, merr, lft, rnd, busy}, ({lef, lec} == '0));
        end
        tick();
        do_release();
        run_bist(-1, -1);
    endtask

    task automatic test_latent_miss();
        do_reset();
        func[5*G] = 1'b1;
        do_release();
        run_bist(5 * G, -1);
        n_checks++;
        if (lft !== 1'b1 || rnd !== 1'b1 || merr !== 1'b0) begin
            n_fail++;
            $display("FAIL latent_miss got lft=%b rnd=%b merr=%b want 1 1 0", lft, rnd, merr);
        end
        repeat (3) tick();
        n_checks++;
        if (lft !== 1'b1) begin
            n_fail++;
            $display("FAIL latent_sticky got %b want 1", lft);
        end
    endtask

    task automatic test_single_group();
        int cnt;
        do_reset();
        do_release();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rnd_s) break;
            if (busy_s) cnt++;
        end
        n_checks++;
        if (cnt != 10 || rnd_s !== 1'b1) begin
            n_fail++;
            $display("FAIL single_group busy_cycles got %0d rnd=%b want 10 1", cnt, rnd_s);
        end
        n_checks++;
        if (lft_s !== 1'b0 || merr_s !== 1'b0) begin
            n_fail++;
            $display("FAIL single_group_flags got lft=%b merr=%b want 0 0", lft_s, merr_s);
        end
    endtask

    initial begin
        func    = '0;
        check   = '0;
        func_s  = '0;
        check_s = '0;
        test_reset();
        test_bist();
        test_bit517();
        test_random_mission();
        test_reset_mid_bist();
        test_latent_miss();
        test_single_group();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
